pwm_bank: RTL
=============

PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter CH_NUM, default 8: number of independent PWM channels.
REQ-002 Parameter CNT_LENGTH, default 16: counter, period and duty width.
REQ-003 Parameter DT_LENGTH, default 8: dead-time counter width.
REQ-004 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-005 sys_clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 sys_rst  input  1  synchronous active-high reset.
REQ-007 pwm_en  input  CH_NUM  per-channel enable.
REQ-008 center_mode  input  CH_NUM  per-channel mode: 1 = center-aligned, 0 = edge-aligned.
REQ-009 max_val  input  CH_NUM*CNT_LENGTH  packed period limits; channel i uses bits [i*CNT_LENGTH +: CNT_LENGTH].
REQ-010 duty_cycle  input  CH_NUM*CNT_LENGTH  packed compare values, same packing as max_val.
REQ-011 dead_time  input  CH_NUM*DT_LENGTH  packed dead-time cycle counts.
REQ-012 pwm_pos  output  CH_NUM  registered main PWM output.
REQ-013 pwm_neg  output  CH_NUM  registered complementary output.
REQ-014 period_pulse  output  CH_NUM  one-cycle strobe at each shadow update point.

Function
REQ-015 Each channel SHALL hold shadow registers: max_a, duty_a, dt_a, mode_a, counter cnt, direction dir and dead-time counter dtc.
REQ-016 While pwm_en[i]=0: shadows load from the inputs every cycle; cnt=0, dir=up, dtc=0; pwm_pos, pwm_neg and period_pulse are 0.
REQ-017 While enabled, shadows SHALL load only at the update point; input changes between update points have no effect.
REQ-018 Edge mode, update point is cnt==max_a: cnt<=0 at that point, cnt<=cnt+1 otherwise. Period = max_a+1 cycles.
REQ-019 Center mode, cnt runs 0,1..max_a,max_a-1..1,0 with period 2*max_a.
REQ-020 Center mode, up with cnt==max_a: dir<=down, cnt<=max_a-1.
REQ-021 Center mode, down with cnt==1: this is the update point; cnt<=0, dir<=up.
REQ-022 Center mode, max_a==1: up with cnt==1 is the update point; cnt<=0, dir stays up.
REQ-023 max_a==0 in either mode: cnt holds 0 and every enabled cycle is an update point.
REQ-024 The raw compare is raw = (cnt < duty_a), unsigned. duty_a==0 gives constant low; duty_a > max_a gives constant high.
REQ-025 period_pulse[i] SHALL assert for exactly the cycle after each update point (registered).
REQ-026 Dead time, on any raw change: dtc<=dt_a and both outputs are driven 0.
REQ-027 While dtc != 0: dtc decrements each cycle and both outputs stay 0.
REQ-028 When dtc == 0: pwm_pos<=raw, pwm_neg<=~raw.
REQ-029 A raw change during a nonzero dtc SHALL restart dtc at dt_a.
REQ-030 With dt_a==0, outputs follow raw with exactly 1 cycle latency; pwm_pos and pwm_neg are never simultaneously 1.
REQ-031 pwm_en falling mid-period SHALL force outputs to 0 on the next cycle.
REQ-032 pwm_en rising: the first enabled cycle has cnt=0, using shadows captured on the last disabled cycle.
REQ-033 Channels SHALL be fully independent; the generate loop replicates one channel slice.

Reset
REQ-034 sys_rst=1 SHALL clear all outputs, counters, dir(=up), dtc and shadows to 0 on the next edge, overriding pwm_en.
REQ-035 Reset asserted mid-period SHALL produce no partial pulse; after release, channels behave as freshly enabled.

Verification
REQ-036 Edge mode, max=9, duty=3, dt=0, enabled → pwm_pos high 3 of every 10 cycles, pwm_neg its complement, period_pulse every 10 cycles.
REQ-037 Center mode, max=4, duty=2 → cnt sequence 0,1,2,3,4,3,2,1 repeating; period 8; pwm_pos high for cnt 0,1.
REQ-038 Edge mode, max=9, duty=5, dt=2 → every raw transition is followed by 2 cycles of both outputs 0; pos high 3, neg high 3 per period.
REQ-039 duty changed 3→7 mid-period → old duty holds until the update point; the next period shows 7 high cycles. duty=0 → constant low; duty=12 with max=9 → constant high.
REQ-040 dt=4 with raw toggling every 2 cycles → both outputs stay 0 throughout (dtc restart).
REQ-041 sys_rst pulsed during an active high phase → all outputs 0 the next cycle; after release, cnt restarts at 0.

Source files
------------

// File: rtl/pwm_bank.sv
// Bank of independent PWM channels with edge/center alignment, period-boundary shadow
// updates and complementary outputs separated by a programmable dead time.
module pwm_bank #(
    parameter int unsigned CH_NUM     = 8,
    parameter int unsigned CNT_LENGTH = 16,
    parameter int unsigned DT_LENGTH  = 8
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst,
    input  logic [CH_NUM-1:0]              pwm_en,
    input  logic [CH_NUM-1:0]              center_mode,
    input  logic [CH_NUM*CNT_LENGTH-1:0]   max_val,
    input  logic [CH_NUM*CNT_LENGTH-1:0]   duty_cycle,
    input  logic [CH_NUM*DT_LENGTH-1:0]    dead_time,
    output logic [CH_NUM-1:0]              pwm_pos,
    output logic [CH_NUM-1:0]              pwm_neg,
    output logic [CH_NUM-1:0]              period_pulse
);

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic [CNT_LENGTH-1:0] max_a, duty_a, cnt, cnt_d;
        logic [DT_LENGTH-1:0]  dt_a, dtc;
        logic                  mode_a, dir_down, dir_d;
        logic                  raw, raw_q, upd;
        logic                  pos_q, neg_q, pulse_q;
        logic [CNT_LENGTH-1:0] max_in, duty_in;
        logic [DT_LENGTH-1:0]  dt_in;

        assign max_in  = max_val[i*CNT_LENGTH +: CNT_LENGTH];
        assign duty_in = duty_cycle[i*CNT_LENGTH +: CNT_LENGTH];
        assign dt_in   = dead_time[i*DT_LENGTH +: DT_LENGTH];

        always_comb begin
            raw   = (cnt < duty_a);
            upd   = 1'b0;
            cnt_d = cnt;
            dir_d = dir_down;
            if (max_a == '0) begin
                upd   = 1'b1;
                cnt_d = '0;
            end else if (!mode_a) begin
                if (cnt == max_a) begin
                    upd   = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt + CNT_LENGTH'(1);
                end
            end else if (!dir_down) begin
                if (cnt != max_a) begin
                    cnt_d = cnt + CNT_LENGTH'(1);
                end else if (max_a == CNT_LENGTH'(1)) begin
                    // A one-step triangle never turns around; the peak is the update point.
                    upd   = 1'b1;
                    cnt_d = '0;
                end else begin
                    dir_d = 1'b1;
                    cnt_d = max_a - CNT_LENGTH'(1);
                end
            end else begin
                if (cnt == CNT_LENGTH'(1)) begin
                    upd   = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt - CNT_LENGTH'(1);
                end
            end
            if (upd) begin
                dir_d = 1'b0;
            end
        end

        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                max_a    <= '0;
                duty_a   <= '0;
                dt_a     <= '0;
                mode_a   <= 1'b0;
                cnt      <= '0;
                dir_down <= 1'b0;
                dtc      <= '0;
                raw_q    <= 1'b0;
                pos_q    <= 1'b0;
                neg_q    <= 1'b0;
                pulse_q  <= 1'b0;
            end else if (!pwm_en[i]) begin
                max_a    <= max_in;
                duty_a   <= duty_in;
                dt_a     <= dt_in;
                mode_a   <= center_mode[i];
                cnt      <= '0;
                dir_down <= 1'b0;
                dtc      <= '0;
                raw_q    <= 1'b0;
                pos_q    <= 1'b0;
                neg_q    <= 1'b0;
                pulse_q  <= 1'b0;
            end else begin
                cnt      <= cnt_d;
                dir_down <= dir_d;
                raw_q    <= raw;
                pulse_q  <= upd;
                if (upd) begin
                    max_a  <= max_in;
                    duty_a <= duty_in;
                    dt_a   <= dt_in;
                    mode_a <= center_mode[i];
                end
                // dtc counts the blanked cycles still owed after the current one, so the
                // total blanking after an edge of raw is exactly dt_a cycles.
                if (raw != raw_q && dt_a != '0) begin
                    dtc   <= dt_a - DT_LENGTH'(1);
                    pos_q <= 1'b0;
                    neg_q <= 1'b0;
                end else if (raw != raw_q) begin
                    dtc   <= '0;
                    pos_q <= raw;
                    neg_q <= ~raw;
                end else if (dtc != '0) begin
                    dtc   <= dtc - DT_LENGTH'(1);
                    pos_q <= 1'b0;
                    neg_q <= 1'b0;
                end else begin
                    pos_q <= raw;
                    neg_q <= ~raw;
                end
            end
        end

        assign pwm_pos[i]      = pos_q;
        assign pwm_neg[i]      = neg_q;
        assign period_pulse[i] = pulse_q;
    end

endmodule
